uart_echo_buf: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_echo_buf_if.sv | 33 +++
 rtl/uart_sync_fifo.sv | 58 +++++
 rtl/uart_echo_buf.sv | 144 ++++++++++++++
 tb/tb_uart_echo_buf.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo buffer.
//   echo_state_t : TX handshake FSM states
//   echo_mode_t  : encodings of the 2-bit mode input
//   ASCII_CR/LF  : characters used by the CR -> CR+LF expansion
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LF,
        START,
        WAIT_HI,
        WAIT_LO
    } echo_state_t;

    typedef enum logic [1:0] {
        MODE_DROP = 2'd0,
        MODE_ECHO = 2'd1,
        MODE_CRLF = 2'd2,
        MODE_RSVD = 2'd3    // treated as MODE_ECHO
    } echo_mode_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_echo_buf_if.sv
// RX/TX handshake bundle between uart_top and uart_echo_buf.
//   rx_data/new_rx_data : received byte and its one-cycle strobe
//   tx_data/tx_begin    : byte to send and its one-cycle start pulse
//   tx_busy             : transmitter busy
// master : echo buffer side (consumes RX, drives TX request)
// slave  : uart_top side
interface uart_echo_buf_if #(
    parameter int DATA_W = 8
) ();

    logic [DATA_W-1:0] rx_data;
    logic              new_rx_data;
    logic [DATA_W-1:0] tx_data;
    logic              tx_begin;
    logic              tx_busy;

    modport master (
        input  rx_data,
        input  new_rx_data,
        input  tx_busy,
        output tx_data,
        output tx_begin
    );

    modport slave (
        output rx_data,
        output new_rx_data,
        output tx_busy,
        input  tx_data,
        input  tx_begin
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clock, reset : clock, asynchronous active-low reset (empties the FIFO)
//   push, din    : write request and data; accepted when not full or when
//                  a pop happens in the same cycle
//   pop, dout    : read request; dout always shows the head entry
//   full, empty  : occupancy flags
//   count        : current occupancy, 0..DEPTH
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        din,
    input  logic                     pop,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_echo_buf.sv
// UART loopback controller with RX buffering.
//   clock, reset  : clock, asynchronous active-low reset
//   mode          : 0 drop, 1 echo, 2 echo with CR -> CR+LF, 3 as 1
//   bus           : RX strobe/data in, TX data/start out, tx_busy in
//   fifo_count    : buffered byte count
//   overflow      : sticky, set when a byte was dropped on a full FIFO
//   overflow_clr  : clears overflow and drop_cnt (a same-cycle drop wins)
//   drop_cnt      : saturating count of dropped bytes
module uart_echo_buf
    import uart_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int ACK_TIMEOUT = 4,
    parameter int DROP_CNT_W  = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [1:0]                    mode,
    uart_echo_buf_if.master               bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          overflow_clr,
    output logic [DROP_CNT_W-1:0]         drop_cnt
);

    localparam int TMR_W = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

    echo_state_t       state;
    echo_state_t       state_nxt;
    echo_mode_t        byte_mode;
    logic              pending_lf;
    logic [TMR_W-1:0]  timer;
    logic [DATA_W-1:0] tx_data_q;
    logic              tx_begin_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_head;
    logic              push_req;
    logic              push_ok;
    logic              drop;

    assign fifo_pop = (state == LOAD);
    assign push_req = bus.new_rx_data && (mode != MODE_DROP);
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok  = push_req && (!fifo_full || fifo_pop);
    assign drop     = push_req && !push_ok;

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_begin = tx_begin_q;

    uart_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_ok),
        .din   (bus.rx_data),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (overflow_clr) begin
                drop_cnt <= DROP_CNT_W'(1);
            end else if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end else if (overflow_clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (pending_lf)       state_nxt = LF;
                else if (!fifo_empty) state_nxt = LOAD;
            end
            LOAD:    state_nxt = START;
            LF:      state_nxt = START;
            START:   state_nxt = WAIT_HI;
            WAIT_HI: begin
                if (bus.tx_busy)            state_nxt = WAIT_LO;
                else if (timer == TMR_LAST) state_nxt = IDLE;
            end
            WAIT_LO: begin
                if (!bus.tx_busy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            byte_mode  <= MODE_DROP;
            pending_lf <= 1'b0;
            timer      <= '0;
            tx_data_q  <= '0;
            tx_begin_q <= 1'b0;
        end else begin
            // Registered start pulse lines up with the START state.
            tx_begin_q <= (state_nxt == START);
            case (state)
                IDLE: begin
                    if (!pending_lf && !fifo_empty) byte_mode <= echo_mode_t'(mode);
                end
                LOAD: begin
                    tx_data_q <= fifo_head;
                    if (byte_mode == MODE_CRLF && fifo_head == DATA_W'(ASCII_CR)) begin
                        pending_lf <= 1'b1;
                    end
                end
                LF: begin
                    tx_data_q  <= DATA_W'(ASCII_LF);
                    pending_lf <= 1'b0;
                end
                START:   timer <= '0;
                WAIT_HI: timer <= timer + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_echo_buf.sv
// Self-checking bench for uart_echo_buf: directed scenarios plus random
// bursts compared against a byte-stream model of the echo rules.
module tb_uart_echo_buf;
    import uart_pkg::*;

    localparam int DATA_W      = 8;
    localparam int FIFO_DEPTH  = 4;
    localparam int ACK_TIMEOUT = 4;
    localparam int DROP_CNT_W  = 3;
    localparam int CW          = $clog2(FIFO_DEPTH) + 1;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [1:0]            mode;
    logic                  overflow_clr;
    logic [CW-1:0]         fifo_count;
    logic                  overflow;
    logic [DROP_CNT_W-1:0] drop_cnt;

    logic man_busy;
    logic auto_busy;
    int   resp_mode = 0;          // 0: bench drives tx_busy, 2: auto responder

    uart_echo_buf_if #(.DATA_W(DATA_W)) bus ();

    assign bus.tx_busy = (resp_mode == 2) ? auto_busy : man_busy;

    uart_echo_buf #(
        .DATA_W      (DATA_W),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .DROP_CNT_W  (DROP_CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .mode         (mode),
        .bus          (bus),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .drop_cnt     (drop_cnt)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    int cyc = 0;
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Record every TX start; check pulse width and spacing after busy falls.
    int         ev_cyc[$];
    logic [7:0] ev_dat[$];
    int         begin_cnt    = 0;
    logic       prev_begin   = 1'b0;
    logic       prev_busy    = 1'b0;
    int         fall_cyc     = 0;
    bit         fall_pending = 1'b0;

    initial forever begin
        @(negedge clock);
        if (bus.tx_begin === 1'b1) begin
            chk("tx_begin_width", 32'(prev_begin), 0);
            if (fall_pending) chk("gap_after_busy_fall", 32'((cyc - fall_cyc) >= 3), 1);
            fall_pending = 1'b0;
            ev_cyc.push_back(cyc);
            ev_dat.push_back(bus.tx_data);
            begin_cnt++;
        end
        if (prev_busy && !bus.tx_busy) begin
            fall_cyc     = cyc;
            fall_pending = 1'b1;
        end
        prev_begin = bus.tx_begin;
        prev_busy  = bus.tx_busy;
    end

    // Transmitter stand-in: after a start pulse, usually goes busy for a
    // random number of cycles, sometimes never answers.
    initial begin
        int seen = 0;
        int left = 0;
        auto_busy = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (left > 0) begin
                left--;
                if (left == 0) auto_busy = 1'b0;
            end
            if (begin_cnt != seen) begin
                seen = begin_cnt;
                if ($urandom_range(0, 4) != 0) begin
                    left      = $urandom_range(1, 6);
                    auto_busy = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data     = b;
        bus.new_rx_data = 1'b1;
        step();
        bus.new_rx_data = 1'b0;
    endtask

    task automatic wait_events(input int n, input int budget);
        int k = 0;
        while (ev_dat.size() < n && k < budget) begin
            step();
            k++;
        end
        chk("event_wait_budget", 32'(ev_dat.size() >= n), 1);
    endtask

    function automatic logic [7:0] dat_at(input int i);
        if (i < ev_dat.size()) return ev_dat[i];
        return 'x;
    endfunction

    function automatic int cyc_at(input int i);
        if (i < ev_cyc.size()) return ev_cyc[i];
        return -1;
    endfunction

    task automatic check_quiet(input string tag);
        chk({tag, "_tx_data"},    32'(bus.tx_data), 0);
        chk({tag, "_tx_begin"},   32'(bus.tx_begin), 0);
        chk({tag, "_fifo_count"}, 32'(fifo_count), 0);
        chk({tag, "_overflow"},   32'(overflow), 0);
        chk({tag, "_drop_cnt"},   32'(drop_cnt), 0);
    endtask

    initial begin
        int         base;
        int         i0;
        int         i1;
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int         m;
        int         n;

        reset           = 1'b0;
        mode            = 2'd1;
        overflow_clr    = 1'b0;
        bus.rx_data     = '0;
        bus.new_rx_data = 1'b0;
        man_busy        = 1'b0;

        idle(3);
        check_quiet("reset");
        reset = 1'b1;
        idle(2);

        // Single echo: strobe at cycle 0, busy high in cycles 2..10.
        mode = 2'd1;
        i0   = ev_dat.size();
        base = cyc;
        for (int i = 0; i < 16; i++) begin
            bus.rx_data     = 8'h41;
            bus.new_rx_data = (i == 0);
            man_busy        = (i >= 2 && i <= 10);
            step();
        end
        bus.new_rx_data = 1'b0;
        chk("echo_count",  32'(ev_dat.size() - i0), 1);
        chk("echo_cycle",  32'(cyc_at(i0) - base), 3);
        chk("echo_data",   32'(dat_at(i0)), 32'h41);
        chk("echo_fifo",   32'(fifo_count), 0);

        // CR expansion.
        mode      = 2'd2;
        resp_mode = 2;
        i0        = ev_dat.size();
        send(ASCII_CR);
        send(8'h42);
        wait_events(i0 + 3, 200);
        idle(30);
        chk("crlf_count", 32'(ev_dat.size() - i0), 3);
        chk("crlf_d0",    32'(dat_at(i0)),     32'h0D);
        chk("crlf_d1",    32'(dat_at(i0 + 1)), 32'h0A);
        chk("crlf_d2",    32'(dat_at(i0 + 2)), 32'h42);
        resp_mode = 0;
        man_busy  = 1'b0;

        // Overflow with the transmitter stuck busy.
        mode     = 2'd1;
        man_busy = 1'b1;
        i0       = ev_dat.size();
        for (int k = 1; k <= 6; k++) send(8'(k));
        idle(2);
        chk("ovf_flag",  32'(overflow),   1);
        chk("ovf_drops", 32'(drop_cnt),   1);
        chk("ovf_count", 32'(fifo_count), 4);
        bus.rx_data     = 8'h07;
        bus.new_rx_data = 1'b1;
        overflow_clr    = 1'b1;
        step();
        bus.new_rx_data = 1'b0;
        overflow_clr    = 1'b0;
        chk("clr_vs_drop_flag",  32'(overflow), 1);
        chk("clr_vs_drop_count", 32'(drop_cnt), 1);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        chk("clr_flag",  32'(overflow), 0);
        chk("clr_count", 32'(drop_cnt), 0);
        for (int k = 0; k < 9; k++) send(8'hEE);
        chk("drop_saturate", 32'(drop_cnt), 7);
        chk("drop_sat_flag", 32'(overflow), 1);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        chk("ovf_started_one", 32'(ev_dat.size() - i0), 1);
        man_busy = 1'b0;
        wait_events(i0 + 5, 200);
        idle(15);
        chk("ovf_drain_count", 32'(ev_dat.size() - i0), 5);
        for (int k = 0; k < 5; k++) chk("ovf_drain_data", 32'(dat_at(i0 + k)), 32'(k + 1));
        chk("ovf_drain_fifo", 32'(fifo_count), 0);
        chk("ovf_cleared",    32'(overflow),   0);

        // Drop mode ignores the strobe entirely.
        mode = 2'd0;
        i0   = ev_dat.size();
        for (int k = 0; k < 3; k++) begin
            send(8'h30 + 8'(k));
            step();
        end
        idle(10);
        chk("dropmode_tx",   32'(ev_dat.size() - i0), 0);
        chk("dropmode_fifo", 32'(fifo_count), 0);
        chk("dropmode_ovf",  32'(overflow),   0);

        // No acknowledge from the transmitter: each byte times out.
        mode     = 2'd1;
        man_busy = 1'b0;
        i0       = ev_dat.size();
        send(8'h55);
        send(8'hAA);
        idle(30);
        chk("timeout_count", 32'(ev_dat.size() - i0), 2);
        chk("timeout_d0",    32'(dat_at(i0)),     32'h55);
        chk("timeout_d1",    32'(dat_at(i0 + 1)), 32'hAA);
        chk("timeout_gap",   32'(cyc_at(i0 + 1) - cyc_at(i0)), 32'(ACK_TIMEOUT + 3));

        // A pending LF is still sent after mode drops to 0.
        mode = 2'd2;
        i0   = ev_dat.size();
        send(ASCII_CR);
        idle(2);
        mode = 2'd0;
        idle(25);
        chk("lf_after_mode0_count", 32'(ev_dat.size() - i0), 2);
        chk("lf_after_mode0_d0",    32'(dat_at(i0)),     32'h0D);
        chk("lf_after_mode0_d1",    32'(dat_at(i0 + 1)), 32'h0A);

        // Reset while waiting for busy to fall, with 3 bytes queued.
        mode     = 2'd1;
        man_busy = 1'b0;
        i0       = ev_dat.size();
        for (int k = 0; k < 4; k++) send(8'hA1 + 8'(k));
        man_busy = 1'b1;
        idle(2);
        chk("pre_reset_fifo", 32'(fifo_count), 3);
        chk("pre_reset_data", 32'(bus.tx_data), 32'hA1);
        #2;
        reset = 1'b0;
        #1;
        check_quiet("async_reset");
        man_busy = 1'b0;
        idle(2);
        reset = 1'b1;
        i1    = ev_dat.size();
        idle(25);
        chk("post_reset_silent", 32'(ev_dat.size() - i1), 0);
        chk("post_reset_fifo",   32'(fifo_count), 0);

        // Random bursts against a byte-stream model.
        resp_mode = 2;
        for (int r = 0; r < 40; r++) begin
            m    = $urandom_range(0, 5);
            if (m > 3) m = 2;
            mode = 2'(m);
            n    = $urandom_range(1, FIFO_DEPTH);
            exp_q.delete();
            i0 = ev_dat.size();
            for (int k = 0; k < n; k++) begin
                b = ($urandom_range(0, 3) == 0) ? ASCII_CR : 8'($urandom);
                send(b);
                if (m != 0) exp_q.push_back(b);
                if (m == 2 && b == ASCII_CR) exp_q.push_back(ASCII_LF);
                idle($urandom_range(0, 2));
            end
            wait_events(i0 + exp_q.size(), 300);
            idle(25);
            chk("rnd_count", 32'(ev_dat.size() - i0), 32'(exp_q.size()));
            for (int j = 0; j < exp_q.size(); j++) chk("rnd_data", 32'(dat_at(i0 + j)), 32'(exp_q[j]));
            chk("rnd_fifo", 32'(fifo_count), 0);
            chk("rnd_ovf",  32'(overflow),   0);
        end
        resp_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
